mp_add_seq: RTL and testbench

- Multi-precision adder sequencer. Adds two WORDS*W-bit operands by time-sharing one W-bit carry-lookahead adder slice over WORDS cycles, chaining the carry through a register.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out).
- Reuses the team's 32-bit CLA datapath for wide arithmetic instead of building a 128-bit combinational CLA.

---
 rtl/mp_add_pkg.sv | 17 +
 rtl/mp_add_seq_cla_slice_cin.sv | 39 +++
 rtl/mp_add_seq.sv | 134 +++++++++++++
 tb/tb_mp_add_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision adder sequencer.
package mp_add_pkg;

    localparam int W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the word index; never narrower than one bit so WORDS=1 still has a register.
    function automatic int idx_w(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/mp_add_seq_cla_slice_cin.sv
// Combinational W-bit carry-lookahead adder slice with carry-in.
// Carries come from a parallel-prefix tree over per-bit generate/propagate terms.
module cla_slice_cin #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gg;
    logic [W-1:0] pg;
    logic [W:0]   c;

    always_comb begin
        g  = x & y;
        p  = x ^ y;
        gg = g;
        pg = p;
        // Fold carry-in into bit 0 so the prefix tree yields carries directly.
        gg[0] = g[0] | (p[0] & ci);
        // Descending i keeps gg[i-d]/pg[i-d] at the previous prefix level.
        for (int d = 1; d < W; d = d * 2) begin
            for (int i = W - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pg[i] & gg[i-d]);
                pg[i] = pg[i] & pg[i-d];
            end
        end
        c[0]   = ci;
        c[W:1] = gg;
        sum    = p ^ c[W-1:0];
        co     = c[W];
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder: time-shares one W-bit CLA slice over WORDS cycles.
// Optional subtract mode (port sub) is enabled by defining MP_ADD_SEQ_SUB_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding word k, carry chained through c_q
// DONE  | result held, out_valid high until out_ready
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W*WORDS-1:0]   a,
    input  logic [W*WORDS-1:0]   b,
`ifdef MP_ADD_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*WORDS:0]     s,
    output logic                 busy
);

    localparam int N  = W * WORDS;
    localparam int KW = idx_w(WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          c_q, c_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N:0]    s_q, s_d;
    logic          out_valid_q, out_valid_d;
    logic          sub_q, sub_d;

    logic [W-1:0]  a_k;
    logic [W-1:0]  b_k;
    logic [W-1:0]  sum_w;
    logic          co_w;

    assign a_k = a_q[k_q*W +: W];
    // Subtract is a + ~b + 1; the +1 enters through the carry loaded at accept.
    assign b_k = b_q[k_q*W +: W] ^ {W{sub_q}};

    cla_slice_cin #(.W(W)) u_slice (
        .x   (a_k),
        .y   (b_k),
        .ci  (c_q),
        .sum (sum_w),
        .co  (co_w)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        c_d         = c_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
        sub_d       = sub_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = '0;
                    k_d     = '0;
`ifdef MP_ADD_SEQ_SUB_EN
                    sub_d   = sub;
                    c_d     = sub;
`else
                    sub_d   = 1'b0;
                    c_d     = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[k_q*W +: W] = sum_w;
                c_d             = co_w;
                if (k_q == K_LAST) begin
                    s_d[N]      = co_w;
                    out_valid_d = 1'b1;
                    k_d         = '0;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            c_q         <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            sub_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            c_q         <= c_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            sub_q       <= sub_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign s         = s_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed and random checks for mp_add_seq (WORDS=4) plus a WORDS=1 instance.
module tb_mp_add_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic [127:0] b;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [128:0] s;
    logic         busy;

    logic         in_valid1;
    logic         in_ready1;
    logic [31:0]  a1;
    logic [31:0]  b1;
    logic         out_valid1;
    logic         out_ready1;
    logic [32:0]  s1;
    logic         busy1;

    int checks = 0;
    int errors = 0;

    mp_add_seq #(.W(32), .WORDS(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef MP_ADD_SEQ_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .busy      (busy)
    );

    mp_add_seq #(.W(32), .WORDS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
`ifdef MP_ADD_SEQ_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .s         (s1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [127:0] av, input logic [127:0] bv, input logic sv);
        chk("in_ready_pre", {128'd0, in_ready}, 129'd1);
        a        = av;
        b        = bv;
        sub_i    = sv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Steps until out_valid (bounded) and checks it took exactly WORDS edges.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, 129'(n), 129'd4);
    endtask

    logic [127:0] av, bv;
    logic         sv;
    logic [128:0] exp_s;
    int           stall;

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        sub_i      = 1'b0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        out_ready1 = 1'b0;
        #12;
        chk("rst_in_ready", {128'd0, in_ready}, 129'd1);
        chk("rst_busy", {128'd0, busy}, 129'd0);
        chk("rst_out_valid", {128'd0, out_valid}, 129'd0);
        chk("rst_s", s, 129'd0);
        rst_n = 1'b1;
        step();

        // Basic add
        accept(128'd5, 128'd7, 1'b0);
        chk("basic_busy", {128'd0, busy}, 129'd1);
        chk("basic_in_ready_run", {128'd0, in_ready}, 129'd0);
        wait_done("basic_lat");
        chk("basic_sum", s, 129'd12);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("basic_release", {127'd0, out_valid, in_ready}, 129'd1);

        // Full ripple
        accept({128{1'b1}}, 128'd1, 1'b0);
        wait_done("ripple_lat");
        chk("ripple_sum", s, 129'h1_00000000_00000000_00000000_00000000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Backpressure
        accept(128'hFFFFFFFF_00000000_FFFFFFFF_00000001, 128'hFFFFFFFF, 1'b0);
        wait_done("bp_lat");
        for (int i = 0; i < 6; i++) begin
            chk("bp_sum", s, 129'h0_FFFFFFFF_00000001_00000000_00000000);
            chk("bp_flags", {126'd0, out_valid, in_ready, busy}, 129'b101);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle", {126'd0, out_valid, in_ready, busy}, 129'b010);
        chk("bp_hold", s, 129'h0_FFFFFFFF_00000001_00000000_00000000);

        // Busy ignore: new request, input changes and out_ready during RUN have no effect
        accept(128'd10, 128'd20, 1'b0);
        in_valid  = 1'b1;
        a         = 128'd111;
        b         = 128'd222;
        out_ready = 1'b1;
        wait_done("busy_lat");
        chk("busy_sum", s, 129'd30);
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("busy_idle", {127'd0, out_valid, in_ready}, 129'd1);
        chk("busy_hold", s, 129'd30);

        // Reset mid-RUN at k=2
        accept(128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 128'h11111111_22222222_33333333_44444444, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rstrun_s", s, 129'd0);
        chk("rstrun_flags", {126'd0, out_valid, in_ready, busy}, 129'b010);
        #2;
        rst_n = 1'b1;
        step();
        accept(128'd1, 128'd1, 1'b0);
        wait_done("rstrun_lat");
        chk("rstrun_after", s, 129'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

`ifdef MP_ADD_SEQ_SUB_EN
        accept(128'd3, 128'd5, 1'b1);
        wait_done("sub_lat");
        chk("sub_3_5", s, 129'h0_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        accept(128'd9, 128'd4, 1'b1);
        wait_done("sub2_lat");
        chk("sub_9_4", s, 129'h1_00000000_00000000_00000000_00000005);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif

        // WORDS=1 instance: single RUN cycle
        chk("w1_in_ready", {128'd0, in_ready1}, 129'd1);
        a1        = 32'hFFFFFFFF;
        b1        = 32'h00000001;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        chk("w1_run", {127'd0, out_valid1, busy1}, 129'b01);
        step();
        chk("w1_done", {127'd0, out_valid1, busy1}, 129'b11);
        chk("w1_sum", {96'd0, s1}, 129'h1_00000000);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        chk("w1_release", {127'd0, out_valid1, in_ready1}, 129'd1);

        // Random operations with stalls
        for (int i = 0; i < 500; i++) begin
            av = {$urandom, $urandom, $urandom, $urandom};
            bv = {$urandom, $urandom, $urandom, $urandom};
            if (i % 50 == 0) begin
                av = {128{1'b1}};
                bv = 128'd1;
            end
`ifdef MP_ADD_SEQ_SUB_EN
            sv = 1'($urandom_range(0, 1));
`else
            sv = 1'b0;
`endif
            if (sv)
                exp_s = {1'b0, av} + {1'b0, ~bv} + 129'd1;
            else
                exp_s = {1'b0, av} + {1'b0, bv};
            accept(av, bv, sv);
            a         = {$urandom, $urandom, $urandom, $urandom};
            b         = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            wait_done("rnd_lat");
            chk("rnd_sum", s, exp_s);
            out_ready = 1'b0;
            stall = $urandom_range(0, 3);
            repeat (stall) step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("rnd_release", {127'd0, out_valid, in_ready}, 129'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
